// File: rtl/wb_port_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin priority,
// a one-cycle registered write stage and a saturating contention counter.
module wb_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              stall_i,
  input  logic              cnt_clr_i,
  output logic              reg_wr_en_o,
  output logic [ADDR_W-1:0] reg_wr_addr_o,
  output logic [DATA_W-1:0] reg_wr_data_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  logic              gnt0_s;
  logic              gnt1_s;
  logic              accept_s;
  logic              conflict_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  logic              ptr_q;
  logic              ptr_d;
  logic              wr_en_q;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] wr_data_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Grant selection: a lone requester always wins, the pointer breaks ties.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst || stall_i) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid_i && req1_valid_i) begin
      case (ptr_q)
        1'b0:    gnt0_s = 1'b1;
        1'b1:    gnt1_s = 1'b1;
        default: gnt0_s = 1'b1;
      endcase
    end else if (req0_valid_i) begin
      gnt0_s = 1'b1;
    end else if (req1_valid_i) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign req0_ready_o = gnt0_s;
  assign req1_ready_o = gnt1_s;
  assign accept_s     = gnt0_s | gnt1_s;
  assign conflict_s   = req0_valid_i & req1_valid_i & ~stall_i;

  // Data path mux feeding the output stage.
  always_comb begin
    sel_addr_s = req0_addr_i;
    sel_data_s = req0_data_i;
    if (gnt1_s) begin
      sel_addr_s = req1_addr_i;
      sel_data_s = req1_data_i;
    end else begin
      sel_addr_s = req0_addr_i;
      sel_data_s = req0_data_i;
    end
  end

  // Next-state for pointer, write stage and counter.
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    if (gnt0_s) begin
      ptr_d = 1'b1;
    end else if (gnt1_s) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end

    // Writes to x0 are consumed but never reach the register file.
    if (accept_s) begin
      wr_en_d   = (sel_addr_s != {ADDR_W{1'b0}});
      wr_addr_d = sel_addr_s;
      wr_data_d = sel_data_s;
    end else begin
      wr_en_d = 1'b0;
    end

    if (cnt_clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (conflict_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign reg_wr_en_o    = wr_en_q;
  assign reg_wr_addr_o  = wr_addr_q;
  assign reg_wr_data_o  = wr_data_q;
  assign conflict_cnt_o = cnt_q;

endmodule
